// File: rtl/bp_me_prefetch_dma_arbiter_if.sv
// DMA-side bundle for the prefetch/demand arbiter: packets, fills, writebacks.
// slave is the arbiter's view, master is the surrounding system's view.
interface bp_me_prefetch_dma_arbiter_if #(
    parameter int daddr_width_p   = 32,
    parameter int l2_fill_width_p = 64
);
    logic [daddr_width_p:0]   cache_dma_pkt_i;
    logic                     cache_dma_pkt_v_i;
    logic                     cache_dma_pkt_ready_and_o;
    logic [daddr_width_p-1:0] pf_addr_i;
    logic                     pf_addr_v_i;
    logic                     pf_addr_ready_and_o;
    logic [daddr_width_p:0]   dma_pkt_o;
    logic                     dma_pkt_v_o;
    logic                     dma_pkt_ready_and_i;
    logic [l2_fill_width_p-1:0] dma_data_i;
    logic                     dma_data_v_i;
    logic                     dma_data_ready_and_o;
    logic [l2_fill_width_p-1:0] cache_dma_data_o;
    logic                     cache_dma_data_v_o;
    logic                     cache_dma_data_ready_and_i;
    logic [l2_fill_width_p-1:0] pf_fill_data_o;
    logic [daddr_width_p-1:0] pf_fill_addr_o;
    logic                     pf_fill_v_o;
    logic                     pf_fill_last_o;
    logic                     pf_fill_ready_and_i;
    logic [l2_fill_width_p-1:0] wb_data_i;
    logic                     wb_data_v_i;
    logic                     wb_data_ready_and_o;
    logic [l2_fill_width_p-1:0] dma_wb_data_o;
    logic                     dma_wb_data_v_o;
    logic                     dma_wb_data_ready_and_i;

    modport slave (
        input  cache_dma_pkt_i, cache_dma_pkt_v_i,
        output cache_dma_pkt_ready_and_o,
        input  pf_addr_i, pf_addr_v_i,
        output pf_addr_ready_and_o,
        output dma_pkt_o, dma_pkt_v_o,
        input  dma_pkt_ready_and_i,
        input  dma_data_i, dma_data_v_i,
        output dma_data_ready_and_o,
        output cache_dma_data_o, cache_dma_data_v_o,
        input  cache_dma_data_ready_and_i,
        output pf_fill_data_o, pf_fill_addr_o, pf_fill_v_o, pf_fill_last_o,
        input  pf_fill_ready_and_i,
        input  wb_data_i, wb_data_v_i,
        output wb_data_ready_and_o,
        output dma_wb_data_o, dma_wb_data_v_o,
        input  dma_wb_data_ready_and_i
    );

    modport master (
        output cache_dma_pkt_i, cache_dma_pkt_v_i,
        input  cache_dma_pkt_ready_and_o,
        output pf_addr_i, pf_addr_v_i,
        input  pf_addr_ready_and_o,
        input  dma_pkt_o, dma_pkt_v_o,
        output dma_pkt_ready_and_i,
        output dma_data_i, dma_data_v_i,
        input  dma_data_ready_and_o,
        input  cache_dma_data_o, cache_dma_data_v_o,
        output cache_dma_data_ready_and_i,
        input  pf_fill_data_o, pf_fill_addr_o, pf_fill_v_o, pf_fill_last_o,
        output pf_fill_ready_and_i,
        output wb_data_i, wb_data_v_i,
        input  wb_data_ready_and_o,
        input  dma_wb_data_o, dma_wb_data_v_o,
        output dma_wb_data_ready_and_i
    );
endinterface

// File: rtl/bp_me_prefetch_dma_arbiter.sv
// Merges demand DMA traffic with prefetch block reads and steers fill beats
// back to the cache or the prefetch buffer using an in-order read tracker.
module bp_me_prefetch_dma_arbiter #(
    parameter int daddr_width_p            = 32,
    parameter int l2_data_width_p          = 64,
    parameter int l2_block_size_in_words_p = 8,
    parameter int l2_fill_width_p          = 64,
    parameter int outstanding_els_p        = 4
) (
    input logic clk_i,
    input logic reset_i,
    bp_me_prefetch_dma_arbiter_if.slave bus
);
    localparam int block_bytes_lp = l2_block_size_in_words_p * l2_data_width_p / 8;
    localparam int beats_lp = l2_block_size_in_words_p * l2_data_width_p / l2_fill_width_p;
    localparam int cnt_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int ptr_w_lp = (outstanding_els_p > 1) ? $clog2(outstanding_els_p) : 1;
    localparam int num_w_lp = $clog2(outstanding_els_p + 1);
    localparam logic [daddr_width_p-1:0] off_mask_lp = daddr_width_p'(block_bytes_lp - 1);
    localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(beats_lp - 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(outstanding_els_p - 1);

    logic                     trk_pf_r   [outstanding_els_p];
    logic [daddr_width_p-1:0] trk_addr_r [outstanding_els_p];
    logic [ptr_w_lp-1:0]      wptr_r, rptr_r;
    logic [num_w_lp-1:0]      num_r;
    logic [cnt_w_lp-1:0]      beat_r;

    logic                     demand_v, demand_wr, demand_rd_v;
    logic [daddr_width_p-1:0] demand_blk, pf_blk, pkt_addr;
    logic                     full, empty, dup, head_pf;
    logic                     push, pop, beat_fire, beat_last;

    assign demand_v    = bus.cache_dma_pkt_v_i;
    assign demand_wr   = bus.cache_dma_pkt_i[daddr_width_p];
    assign demand_rd_v = demand_v & ~demand_wr;
    assign demand_blk  = bus.cache_dma_pkt_i[daddr_width_p-1:0] & ~off_mask_lp;
    assign pf_blk      = bus.pf_addr_i & ~off_mask_lp;
    assign full        = (num_r == num_w_lp'(outstanding_els_p));
    assign empty       = (num_r == '0);
    assign head_pf     = trk_pf_r[rptr_r];
    assign beat_last   = (beat_r == last_beat_lp);
    // A demand read of the same block makes the prefetch redundant.
    assign dup = bus.pf_addr_v_i & demand_rd_v & (pf_blk == demand_blk);

    always_comb begin
        bus.dma_pkt_o = demand_v ? bus.cache_dma_pkt_i : {1'b0, pf_blk};
        bus.dma_pkt_v_o = 1'b0;
        bus.cache_dma_pkt_ready_and_o = 1'b0;
        bus.pf_addr_ready_and_o = 1'b0;
        bus.dma_data_ready_and_o = 1'b0;
        bus.cache_dma_data_v_o = 1'b0;
        bus.pf_fill_v_o = 1'b0;
        bus.pf_fill_last_o = 1'b0;
        bus.wb_data_ready_and_o = 1'b0;
        bus.dma_wb_data_v_o = 1'b0;
        if (!reset_i) begin
            bus.dma_pkt_v_o = demand_v ? (demand_wr | ~full)
                                       : (bus.pf_addr_v_i & ~full);
            bus.cache_dma_pkt_ready_and_o = bus.dma_pkt_ready_and_i & (demand_wr | ~full);
            bus.pf_addr_ready_and_o = dup | (~demand_v & ~full & bus.dma_pkt_ready_and_i);
            if (!empty) begin
                bus.cache_dma_data_v_o = ~head_pf & bus.dma_data_v_i;
                bus.pf_fill_v_o = head_pf & bus.dma_data_v_i;
                bus.pf_fill_last_o = head_pf & beat_last;
                bus.dma_data_ready_and_o = head_pf ? bus.pf_fill_ready_and_i
                                                   : bus.cache_dma_data_ready_and_i;
            end
            bus.wb_data_ready_and_o = bus.dma_wb_data_ready_and_i;
            bus.dma_wb_data_v_o = bus.wb_data_v_i;
        end
    end

    assign bus.cache_dma_data_o = bus.dma_data_i;
    assign bus.pf_fill_data_o   = bus.dma_data_i;
    assign bus.pf_fill_addr_o   = trk_addr_r[rptr_r];
    assign bus.dma_wb_data_o    = bus.wb_data_i;

    assign pkt_addr  = bus.dma_pkt_o[daddr_width_p-1:0] & ~off_mask_lp;
    assign push      = bus.dma_pkt_v_o & bus.dma_pkt_ready_and_i & ~bus.dma_pkt_o[daddr_width_p];
    assign beat_fire = bus.dma_data_v_i & bus.dma_data_ready_and_o;
    assign pop       = beat_fire & beat_last;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            num_r  <= '0;
            beat_r <= '0;
        end else begin
            if (push)
                wptr_r <= (wptr_r == last_ptr_lp) ? '0 : wptr_r + 1'b1;
            if (pop)
                rptr_r <= (rptr_r == last_ptr_lp) ? '0 : rptr_r + 1'b1;
            if (beat_fire)
                beat_r <= beat_last ? '0 : beat_r + 1'b1;
            num_r <= num_r + num_w_lp'(push) - num_w_lp'(pop);
        end
    end

    // Entry payload needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            trk_pf_r[wptr_r]   <= ~demand_v;
            trk_addr_r[wptr_r] <= pkt_addr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i)
            assert (!(bus.dma_data_v_i && empty));
    end
endmodule

// File: tb/tb_bp_me_prefetch_dma_arbiter.sv
// Directed vector table for the packet path plus scripted fill sequences.
module tb_bp_me_prefetch_dma_arbiter;
  typedef struct {
    logic        cv;
    logic [32:0] cpkt;
    logic        pv;
    logic [31:0] pa;
    logic        drdy;
    logic        wbv;
    logic        wbr;
    logic        ev;
    logic [32:0] epkt;
    logic        ecr;
    logic        epr;
  } vec_t;

  typedef struct {
    logic        pf;
    logic [31:0] addr;
  } trk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   beat_no = 0;
  int   blk_no = 0;
  trk_t exp_q[$];
  vec_t vt[10];

  always #5 clk = ~clk;

  bp_me_prefetch_dma_arbiter_if #(
    .daddr_width_p(32),
    .l2_fill_width_p(64)
  ) bus ();

  bp_me_prefetch_dma_arbiter dut (
    .clk_i(clk),
    .reset_i(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    bus.cache_dma_pkt_i = '0;
    bus.cache_dma_pkt_v_i = 1'b0;
    bus.pf_addr_i = '0;
    bus.pf_addr_v_i = 1'b0;
    bus.dma_pkt_ready_and_i = 1'b0;
    bus.dma_data_i = '0;
    bus.dma_data_v_i = 1'b0;
    bus.cache_dma_data_ready_and_i = 1'b0;
    bus.pf_fill_ready_and_i = 1'b0;
    bus.wb_data_i = '0;
    bus.wb_data_v_i = 1'b0;
    bus.dma_wb_data_ready_and_i = 1'b0;
  endtask

  function automatic logic [63:0] bdata();
    return {32'(blk_no), 32'(beat_no)};
  endfunction

  task automatic adv();
    beat_no++;
    if (beat_no == 8) begin
      beat_no = 0;
      blk_no++;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic issue(input logic pf, input logic wr, input logic [31:0] a);
    logic [31:0] ea;
    ea = pf ? {a[31:6], 6'd0} : a;
    if (pf) begin
      bus.pf_addr_i = a;
      bus.pf_addr_v_i = 1'b1;
    end else begin
      bus.cache_dma_pkt_i = {wr, a};
      bus.cache_dma_pkt_v_i = 1'b1;
    end
    bus.dma_pkt_ready_and_i = 1'b1;
    #1;
    chk("issue_v", 64'(bus.dma_pkt_v_o), 64'd1);
    chk("issue_pkt", 64'(bus.dma_pkt_o), 64'({wr, ea}));
    chk("issue_rdy", 64'(pf ? bus.pf_addr_ready_and_o
                            : bus.cache_dma_pkt_ready_and_o), 64'd1);
    tick();
    if (!wr) exp_q.push_back('{pf, {ea[31:6], 6'd0}});
    clr();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        chk("drain_q", 64'd0, 64'd1);
        return;
      end
      bus.dma_data_i = bdata();
      bus.dma_data_v_i = 1'b1;
      bus.cache_dma_data_ready_and_i = 1'b1;
      bus.pf_fill_ready_and_i = 1'b1;
      #1;
      chk("fill_rdy", 64'(bus.dma_data_ready_and_o), 64'd1);
      if (exp_q[0].pf) begin
        chk("pf_v", 64'(bus.pf_fill_v_o), 64'd1);
        chk("pf_cache_v", 64'(bus.cache_dma_data_v_o), 64'd0);
        chk("pf_data", bus.pf_fill_data_o, bdata());
        chk("pf_addr", 64'(bus.pf_fill_addr_o), 64'(exp_q[0].addr));
        chk("pf_last", 64'(bus.pf_fill_last_o), 64'(beat_no == 7));
      end else begin
        chk("dm_v", 64'(bus.cache_dma_data_v_o), 64'd1);
        chk("dm_pf_v", 64'(bus.pf_fill_v_o), 64'd0);
        chk("dm_data", bus.cache_dma_data_o, bdata());
      end
      tick();
      adv();
      clr();
    end
  endtask

  task automatic chk_empty(input string nm);
    bus.cache_dma_data_ready_and_i = 1'b1;
    bus.pf_fill_ready_and_i = 1'b1;
    #1;
    chk(nm, 64'(bus.dma_data_ready_and_o), 64'd0);
    clr();
  endtask

  initial begin
    logic dv, cr, pr, ep, fired;
    vt[0] = '{1'b0, 33'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
              1'b0, 33'h0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 33'h0_0000_1000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1,
              1'b1, 33'h0_0000_1000, 1'b1, 1'b0};
    vt[2] = '{1'b1, 33'h1_0000_1040, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0,
              1'b1, 33'h1_0000_1040, 1'b1, 1'b0};
    vt[3] = '{1'b0, 33'h0, 1'b1, 32'h2044, 1'b1, 1'b0, 1'b1,
              1'b1, 33'h0_0000_2040, 1'b0, 1'b1};
    vt[4] = '{1'b0, 33'h0, 1'b1, 32'h2044, 1'b0, 1'b0, 1'b0,
              1'b1, 33'h0_0000_2040, 1'b0, 1'b0};
    vt[5] = '{1'b1, 33'h0_0000_3000, 1'b1, 32'h3010, 1'b1, 1'b0, 1'b0,
              1'b1, 33'h0_0000_3000, 1'b1, 1'b1};
    vt[6] = '{1'b1, 33'h0_0000_3000, 1'b1, 32'h3050, 1'b1, 1'b0, 1'b0,
              1'b1, 33'h0_0000_3000, 1'b1, 1'b0};
    vt[7] = '{1'b1, 33'h1_0000_3000, 1'b1, 32'h3010, 1'b1, 1'b0, 1'b0,
              1'b1, 33'h1_0000_3000, 1'b1, 1'b0};
    vt[8] = '{1'b1, 33'h0_0000_4000, 1'b1, 32'h4008, 1'b0, 1'b0, 1'b0,
              1'b1, 33'h0_0000_4000, 1'b0, 1'b1};
    vt[9] = '{1'b0, 33'h0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0,
              1'b1, 33'h0_7FFF_FFC0, 1'b0, 1'b1};

    clr();
    @(negedge clk);
    @(negedge clk);
    bus.cache_dma_pkt_v_i = 1'b1;
    bus.pf_addr_v_i = 1'b1;
    bus.dma_pkt_ready_and_i = 1'b1;
    bus.wb_data_v_i = 1'b1;
    bus.dma_wb_data_ready_and_i = 1'b1;
    bus.cache_dma_data_ready_and_i = 1'b1;
    bus.pf_fill_ready_and_i = 1'b1;
    #1;
    chk("rst_pkt_v", 64'(bus.dma_pkt_v_o), 64'd0);
    chk("rst_c_rdy", 64'(bus.cache_dma_pkt_ready_and_o), 64'd0);
    chk("rst_pf_rdy", 64'(bus.pf_addr_ready_and_o), 64'd0);
    chk("rst_wb", 64'({bus.dma_wb_data_v_o, bus.wb_data_ready_and_o}), 64'd0);
    chk("rst_fill", 64'({bus.cache_dma_data_v_o, bus.pf_fill_v_o,
                          bus.dma_data_ready_and_o}), 64'd0);
    clr();
    rst = 1'b0;
    chk_empty("rst_empty");

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.cache_dma_pkt_v_i = vt[i].cv;
      bus.cache_dma_pkt_i = vt[i].cpkt;
      bus.pf_addr_v_i = vt[i].pv;
      bus.pf_addr_i = vt[i].pa;
      bus.dma_pkt_ready_and_i = vt[i].drdy;
      bus.wb_data_v_i = vt[i].wbv;
      bus.wb_data_i = 64'hC0DE_0000_0000_0000 | 64'(i);
      bus.dma_wb_data_ready_and_i = vt[i].wbr;
      #1;
      chk($sformatf("vec%0d_v", i), 64'(bus.dma_pkt_v_o), 64'(vt[i].ev));
      if (vt[i].ev)
        chk($sformatf("vec%0d_pkt", i), 64'(bus.dma_pkt_o), 64'(vt[i].epkt));
      if (vt[i].cv)
        chk($sformatf("vec%0d_crdy", i), 64'(bus.cache_dma_pkt_ready_and_o),
            64'(vt[i].ecr));
      if (vt[i].pv)
        chk($sformatf("vec%0d_prdy", i), 64'(bus.pf_addr_ready_and_o),
            64'(vt[i].epr));
      chk($sformatf("vec%0d_wbv", i), 64'(bus.dma_wb_data_v_o), 64'(vt[i].wbv));
      chk($sformatf("vec%0d_wbr", i), 64'(bus.wb_data_ready_and_o), 64'(vt[i].wbr));
      if (vt[i].wbv)
        chk($sformatf("vec%0d_wbd", i), bus.dma_wb_data_o,
            64'hC0DE_0000_0000_0000 | 64'(i));
      clr();
    end
    @(negedge clk);

    issue(1'b0, 1'b0, 32'h1000);
    drain(8);
    chk_empty("t1_empty");

    issue(1'b1, 1'b0, 32'h2044);
    drain(8);
    chk_empty("t2_empty");

    bus.cache_dma_pkt_i = {1'b0, 32'h3000};
    bus.cache_dma_pkt_v_i = 1'b1;
    bus.pf_addr_i = 32'h3010;
    bus.pf_addr_v_i = 1'b1;
    bus.dma_pkt_ready_and_i = 1'b1;
    #1;
    chk("dup_pkt", 64'(bus.dma_pkt_o), 64'h0_0000_3000);
    chk("dup_prdy", 64'(bus.pf_addr_ready_and_o), 64'd1);
    tick();
    exp_q.push_back('{1'b0, 32'h3000});
    clr();
    bus.dma_pkt_ready_and_i = 1'b1;
    #1;
    chk("dup_one_pkt", 64'(bus.dma_pkt_v_o), 64'd0);
    clr();
    drain(8);

    issue(1'b1, 1'b0, 32'h5000);
    issue(1'b1, 1'b0, 32'h5044);
    issue(1'b1, 1'b0, 32'h5080);
    issue(1'b1, 1'b0, 32'h50C0);
    bus.pf_addr_i = 32'h5100;
    bus.pf_addr_v_i = 1'b1;
    bus.dma_pkt_ready_and_i = 1'b1;
    #1;
    chk("full_pf_v", 64'(bus.dma_pkt_v_o), 64'd0);
    chk("full_pf_rdy", 64'(bus.pf_addr_ready_and_o), 64'd0);
    clr();
    bus.cache_dma_pkt_i = {1'b0, 32'h5200};
    bus.cache_dma_pkt_v_i = 1'b1;
    bus.dma_pkt_ready_and_i = 1'b1;
    #1;
    chk("full_rd_v", 64'(bus.dma_pkt_v_o), 64'd0);
    chk("full_rd_rdy", 64'(bus.cache_dma_pkt_ready_and_o), 64'd0);
    bus.cache_dma_pkt_i = {1'b1, 32'h5300};
    #1;
    chk("full_wr_v", 64'(bus.dma_pkt_v_o), 64'd1);
    chk("full_wr_rdy", 64'(bus.cache_dma_pkt_ready_and_o), 64'd1);
    clr();
    drain(8);
    issue(1'b0, 1'b0, 32'h5200);
    drain(32);
    chk_empty("full_empty");

    issue(1'b0, 1'b0, 32'h8000);
    issue(1'b1, 1'b0, 32'h9004);
    issue(1'b0, 1'b0, 32'hA000);
    for (int cyc = 0; cyc < 600 && exp_q.size() != 0; cyc++) begin
      dv = 1'($urandom_range(0, 1));
      cr = 1'($urandom_range(0, 1));
      pr = 1'($urandom_range(0, 1));
      ep = exp_q[0].pf;
      bus.dma_data_v_i = dv;
      bus.dma_data_i = bdata();
      bus.cache_dma_data_ready_and_i = cr;
      bus.pf_fill_ready_and_i = pr;
      #1;
      if (dv) begin
        chk("rnd_cv", 64'(bus.cache_dma_data_v_o), 64'(!ep));
        chk("rnd_pv", 64'(bus.pf_fill_v_o), 64'(ep));
        chk("rnd_data", ep ? bus.pf_fill_data_o : bus.cache_dma_data_o, bdata());
        chk("rnd_rdy", 64'(bus.dma_data_ready_and_o), 64'(ep ? pr : cr));
        if (ep) begin
          chk("rnd_addr", 64'(bus.pf_fill_addr_o), 64'(exp_q[0].addr));
          chk("rnd_last", 64'(bus.pf_fill_last_o), 64'(beat_no == 7));
        end
      end
      fired = dv & (ep ? pr : cr);
      tick();
      if (fired) adv();
      clr();
    end
    chk("rnd_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    beat_no = 0;
    chk_empty("rnd_empty");

    issue(1'b0, 1'b0, 32'h6000);
    drain(3);
    bus.dma_data_i = bdata();
    bus.dma_data_v_i = 1'b1;
    bus.cache_dma_data_ready_and_i = 1'b1;
    bus.cache_dma_pkt_i = {1'b0, 32'h6100};
    bus.cache_dma_pkt_v_i = 1'b1;
    bus.dma_pkt_ready_and_i = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_v", 64'({bus.cache_dma_data_v_o, bus.dma_pkt_v_o}), 64'd0);
    chk("mid_rst_rdy", 64'(bus.dma_data_ready_and_o), 64'd0);
    tick();
    clr();
    rst = 1'b0;
    exp_q.delete();
    beat_no = 0;
    blk_no = 100;
    chk_empty("mid_rst_empty");
    issue(1'b0, 1'b0, 32'h7000);
    drain(8);
    chk_empty("post_rst_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bp_me_prefetch_dma_arbiter.md
Name: bp_me_prefetch_dma_arbiter

Overview:
- Sits between one L2 bank's bsg_cache DMA port and the DRAM DMA link, downstream of the cache bank and of the best-offset prefetch address FIFO.
- Merges demand DMA packets (reads and writebacks) from the cache with prefetch block reads.
- Tracks outstanding reads in order and steers returning fill beats either to the cache or to the prefetch buffer fill port.

Parameters:
- daddr_width_p, 32: DRAM byte address width.
- l2_data_width_p, 64: cache word width.
- l2_block_size_in_words_p, 8: words per block.
- l2_fill_width_p, 64: DMA beat width. Beats per block = block_size*data_width/fill_width (8).
- outstanding_els_p, 4: read tracker depth.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cache_dma_pkt_i  in  1+daddr_width_p  bit[daddr_width_p] = write_not_read; low bits = addr
- cache_dma_pkt_v_i  in  1  demand packet valid
- cache_dma_pkt_ready_and_o  out  1  demand packet accepted
- pf_addr_i  in  daddr_width_p  prefetch block address
- pf_addr_v_i  in  1  prefetch request valid
- pf_addr_ready_and_o  out  1  prefetch request consumed (issued or dropped)
- dma_pkt_o  out  1+daddr_width_p  packet to DRAM, same format
- dma_pkt_v_o  out  1  packet valid
- dma_pkt_ready_and_i  in  1  DRAM accepts packet
- dma_data_i  in  l2_fill_width_p  read beat from DRAM
- dma_data_v_i  in  1  read beat valid
- dma_data_ready_and_o  out  1  read beat accepted
- cache_dma_data_o  out  l2_fill_width_p  demand fill beat to cache
- cache_dma_data_v_o  out  1  demand fill beat valid
- cache_dma_data_ready_and_i  in  1  cache accepts demand fill beat
- pf_fill_data_o  out  l2_fill_width_p  prefetch fill beat
- pf_fill_addr_o  out  daddr_width_p  block-aligned address of the current prefetch fill
- pf_fill_v_o  out  1  prefetch fill beat valid
- pf_fill_last_o  out  1  final beat of the block
- pf_fill_ready_and_i  in  1  prefetch buffer accepts beat
- wb_data_i / wb_data_v_i / wb_data_ready_and_o  in/in/out  fill_width/1/1  writeback data from the cache
- dma_wb_data_o / dma_wb_data_v_o / dma_wb_data_ready_and_i  out/out/in  fill_width/1/1  writeback data to DRAM

Behaviour:
- Reset (sync, active-high): tracker empty; beat counter 0; all v_o and ready_and_o outputs low during reset.
- Any reset mid-operation discards in-flight tracking.
- Packet path is combinational, 0-cycle latency.
- Arbitration uses strict demand priority:
  - Demand write: forwarded whenever cache_dma_pkt_v_i; not tracked.
  - Demand read: forwarded only if tracker not full.
  - Prefetch: forwarded only if no demand packet is valid and tracker not full.
- Prefetch address is aligned before issue: low log2(block bytes) bits forced to 0.
- Duplicate drop: if pf_addr_v_i and a valid demand read targets the same block in the same cycle, pf_addr_ready_and_o=1, the prefetch is dropped, and nothing is issued for it.
- Tracker: in-order FIFO of {is_prefetch, block_addr}.
  - Push on dma_pkt_v_o & dma_pkt_ready_and_i & read.
  - Pop on the last accepted beat.
  - Full is evaluated from registered state.
  - Push and pop in the same cycle are legal when not full.
- Fill routing uses the tracker head:
  - Head is demand: cache_dma_data_v_o = dma_data_v_i; dma_data_ready_and_o = cache_dma_data_ready_and_i.
  - Head is prefetch: pf_fill_v_o = dma_data_v_i; pf_fill_addr_o = head address; pf_fill_last_o = (counter == beats-1); dma_data_ready_and_o = pf_fill_ready_and_i.
  - Tracker empty: dma_data_ready_and_o = 0. A beat arriving with an empty tracker is an assertion error.
- Beat counter increments per accepted beat and wraps to 0 after beats-1; the wrap pops the tracker.
- Writeback data passes straight through combinationally: valid and data forward, ready returns.

Test Plan:
- Single demand read of 0x1000 -> one dma_pkt with write bit 0; 8 beats D0..D7 appear on cache_dma_data_o; tracker empty afterwards.
- Prefetch 0x2044 alone -> dma_pkt addr 0x2040; 8 beats go to the pf fill port with pf_fill_addr_o=0x2040; pf_fill_last_o only on beat 7.
- Demand read 0x3000 and prefetch 0x3010 in the same cycle -> demand issued; prefetch consumed and dropped; exactly one dma_pkt.
- 4 prefetches issued, DRAM silent -> a 5th prefetch and a demand read are both stalled; a demand write still passes; after 8 beats return, the demand read issues.
- Interleaved demand/prefetch/demand reads with random fill and ready backpressure -> beats are delivered in issue order to the correct consumers with no loss or duplication.
- Reset asserted mid-fill (beat 3) -> next cycle all valids low and tracker empty; a new read completes normally.
